// File: rtl/eth_rx_mii_packer.sv
// eth_rx_mii_packer
//   MII receive front end. Strips preamble/SFD, packs nibbles (low first)
//   into two-byte words with frame flags, buffers them in a small FIFO and
//   paces single-cycle load strobes toward the clock-domain synchronizer.
//
// Ports
//   clk      MII rx clock
//   res      synchronous active-high reset
//   rxd      MII receive nibble
//   rx_dv    MII receive data valid
//   rx_er    MII receive error
//   dout     [19] ODD, [18] ERR, [17] EOF, [16] SOF, [15:8] byte 2, [7:0] byte 1
//   ena_buf  one-cycle load strobe, dout valid while high
//   ovf      one-cycle pulse when a word is discarded on a full FIFO
//
// Build option
//   ETH_RX_PACK_CRC_EN  adds a nibble-serial CRC-32 check; a bad FCS sets ERR
//                       on the EOF word.

module eth_rx_mii_packer #(
    parameter int FIFO_AW = 3,
    parameter int GAP     = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [19:0] dout,
    output logic        ena_buf,
    output logic        ovf
);

    localparam int                DEPTH   = 1 << FIFO_AW;
    localparam int                GW      = $clog2(GAP + 1);
    localparam logic [FIFO_AW:0]  DEPTH_W = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]  DEPTH_M = (FIFO_AW + 1)'(DEPTH - 1);
    localparam logic [GW-1:0]     GAP_LD  = GW'(GAP - 1);

    typedef enum logic [2:0] {S_DROP, S_IDLE, S_PRE, S_DATA, S_FLUSH} state_t;

    state_t state, state_nx;

    // parser datapath
    logic        seen5;
    logic        half;       // low nibble of current byte captured
    logic [3:0]  lo_nib;
    logic        have_b0;    // first byte of current word captured
    logic [7:0]  byte0;
    logic        hold_vld;
    logic        hold_sof;
    logic [15:0] hold_data;
    logic        first_w;    // no word of this frame completed yet
    logic        err_st;
    logic        discard;    // a push of this frame was refused
    logic        crc_bad;

    // push side
    logic        push, push_eof, can_push, wr_ok, refuse;
    logic [19:0] push_word;
    logic        err_fin;

    // FIFO
    logic [19:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0]   cnt;
    logic [GW-1:0]      gap;
    logic               pop;

`ifdef ETH_RX_PACK_CRC_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'h0, d};
        for (int i = 0; i < 4; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // The good-FCS residue 0xC704DD7B is expressed MSB-first; the shift
    // register runs LSB-first, so compare it bit-reversed.
    assign crc_bad = (bitrev(crc) != 32'hC704DD7B);

    always_ff @(posedge clk) begin
        if (res)
            crc <= 32'hFFFFFFFF;
        else if (state == S_PRE && state_nx == S_DATA)
            crc <= 32'hFFFFFFFF;
        else if (state == S_DATA && rx_dv)
            crc <= crc_nib(crc, rxd);
    end
`else
    assign crc_bad = 1'b0;
`endif

    // An odd nibble count (half still set at FLUSH) is a dribble error.
    assign err_fin = err_st | half | crc_bad;

    always_ff @(posedge clk) begin
        if (res) state <= S_DROP;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_eof  = 1'b0;
        push_word = '0;
        case (state)
            S_DROP:  if (!rx_dv) state_nx = S_IDLE;
            S_IDLE:  if (rx_dv) state_nx = S_PRE;
            S_PRE: begin
                if (!rx_dv)                      state_nx = S_IDLE;
                else if (rxd == 4'h5)            state_nx = S_PRE;
                else if (rxd == 4'hD && seen5)   state_nx = S_DATA;
                else                             state_nx = S_DROP;
            end
            S_DATA: begin
                if (!rx_dv) begin
                    state_nx = S_FLUSH;
                end else if (half && have_b0 && hold_vld && !discard) begin
                    // a new word completes: release the previous one
                    push      = 1'b1;
                    push_word = {3'b000, hold_sof, hold_data};
                end
            end
            S_FLUSH: begin
                state_nx = S_IDLE;
                if (discard) begin
                    push      = 1'b1;
                    push_eof  = 1'b1;
                    push_word = {4'b0110, 16'h0000};
                end else if (hold_vld) begin
                    push      = 1'b1;
                    push_eof  = !have_b0;
                    push_word = {1'b0, err_fin & !have_b0, !have_b0, hold_sof, hold_data};
                    if (have_b0) state_nx = S_FLUSH;
                end else if (have_b0) begin
                    push      = 1'b1;
                    push_eof  = 1'b1;
                    push_word = {1'b1, err_fin, 1'b1, first_w, 8'h00, byte0};
                end
            end
            default: state_nx = S_DROP;
        endcase

        // non-EOF words leave one slot free so the frame can always be closed
        can_push = push_eof ? (cnt < DEPTH_W) : (cnt < DEPTH_M);
        wr_ok    = push && can_push;
        refuse   = push && !can_push;

        // a refused flush word is replaced by the terminator next cycle
        if (state == S_FLUSH && refuse && !discard) state_nx = S_FLUSH;
    end

    // parser datapath
    always_ff @(posedge clk) begin
        if (res) begin
            seen5     <= 1'b0;
            half      <= 1'b0;
            lo_nib    <= '0;
            have_b0   <= 1'b0;
            byte0     <= '0;
            hold_vld  <= 1'b0;
            hold_sof  <= 1'b0;
            hold_data <= '0;
            first_w   <= 1'b0;
            err_st    <= 1'b0;
            discard   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= refuse;
            if (refuse) discard <= 1'b1;

            if (state == S_PRE && rxd == 4'h5) seen5 <= 1'b1;
            if (state == S_IDLE)               seen5 <= 1'b0;

            if (state == S_PRE && state_nx == S_DATA) begin
                half     <= 1'b0;
                have_b0  <= 1'b0;
                hold_vld <= 1'b0;
                first_w  <= 1'b1;
                err_st   <= 1'b0;
                discard  <= 1'b0;
            end

            if (state == S_DATA) begin
                if (rx_er) err_st <= 1'b1;
                if (rx_dv) begin
                    if (!half) begin
                        lo_nib <= rxd;
                        half   <= 1'b1;
                    end else begin
                        half <= 1'b0;
                        if (!have_b0) begin
                            byte0   <= {rxd, lo_nib};
                            have_b0 <= 1'b1;
                        end else begin
                            have_b0   <= 1'b0;
                            hold_data <= {rxd, lo_nib, byte0};
                            hold_sof  <= first_w;
                            hold_vld  <= 1'b1;
                            first_w   <= 1'b0;
                        end
                    end
                end
            end

            if (state == S_FLUSH && !discard && !refuse) begin
                if (hold_vld) hold_vld <= 1'b0;
                else          have_b0  <= 1'b0;
            end
        end
    end

    // FIFO and strobe pacing
    assign pop = (cnt != '0) && (gap == '0);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            gap     <= '0;
            dout    <= '0;
            ena_buf <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (pop)   rp <= rp + 1'b1;
            cnt <= cnt + {{FIFO_AW{1'b0}}, wr_ok} - {{FIFO_AW{1'b0}}, pop};
            ena_buf <= pop;
            if (pop) begin
                dout <= mem[rp];
                gap  <= GAP_LD;
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

endmodule
